wb_stage: RTL and testbench
===========================

# wb_stage

Write-back stage of the 5-stage CPU pipeline: the write side of the register-file interface whose read side is decoded in ID. It accepts completed results from MEM through a valid/ready handshake and buffers them in a small in-order FIFO. It drives the register-file write port under a grant, exposes forwarding lookups so ID can see values not yet written, and counts retired instructions.

## Interface
Parameters:
- DATA_W, 32, register data width
- ADDR_W, 5, register index width (32 registers, r0 hard-wired zero)
- DEPTH, 2, write-back buffer entries (power of two, ≥2)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-low reset (asserted when 0)
- in_valid  in  1  MEM presents a completed instruction
- in_ready  out  1  stage can accept this cycle
- in_wen  in  1  instruction writes a destination register
- in_rd  in  ADDR_W  destination register index
- in_data  in  DATA_W  result value
- rf_we  out  1  register-file write request
- rf_waddr  out  ADDR_W  write index
- rf_wdata  out  DATA_W  write data
- rf_grant  in  1  register file accepts the write this cycle
- fwd_rs, fwd_rt  in  ADDR_W each  ID source indices to look up
- fwd_rs_hit, fwd_rt_hit  out  1 each  pending write exists for that index
- fwd_rs_data, fwd_rt_data  out  DATA_W each  value of youngest pending write
- retired_cnt  out  32  instructions retired since reset

## Operation
- Push: in_valid && in_ready at an edge enqueues {in_wen, in_rd, in_data} at the tail.
- in_ready = (count < DEPTH), from registered count only. A full buffer does not accept, even if it pops in the same cycle.
- Head is "writing" iff valid && wen && rd != 0. Writes to r0 and entries with wen=0 are non-writing.
- rf_we = head writing; rf_waddr/rf_wdata = head rd/data when rf_we, else 0.
- Pop: head valid && (!head writing || rf_grant). Non-writing entries retire in one cycle without needing a grant.
- rf_grant low with rf_we high: head held, rf_we/addr/data stable until granted.
- retired_cnt += 1 on every pop; wraps 2^32-1 → 0.
- Forwarding (combinational): hit when any valid writing entry has rd == lookup index. Data comes from the youngest such entry (tail-most). Index 0 never hits; data is 0 on miss.
- Simultaneous push and pop with count between 1 and DEPTH-1: count unchanged, both pointers advance.
- Pointers wrap modulo DEPTH; count is ADDR of log2(DEPTH)+1 bits.
- Reset mid-operation: all buffered entries discarded, no write issued in the reset cycle.

## Timing
- Reset values: in_ready=1 (after reset edge), rf_we=0, rf_waddr=0, rf_wdata=0, all fwd hits 0, fwd data 0, retired_cnt=0, count=0, pointers 0.
- Latency: entry accepted at edge N into an empty buffer drives rf_we in the cycle after N. With rf_grant=1 it pops at edge N+1.
- Sustained throughput: 1 instruction/cycle while rf_grant stays high.
- A forwarding hit is visible in the cycle after push and ends in the cycle after its pop.

## Structure
- Shared package cpu_pkg: DATA_W, REG_ADDR_W, REG_COUNT constants; typedef wb_entry_t struct {wen, rd, data}.
- Sub-module wb_fifo: parameterised DEPTH-entry FIFO of wb_entry_t with push/pop/count. It exposes all entries plus valid bits for the forwarding search.
- The forwarding search and counter live in wb_stage.

## Test plan
- Reset then push {wen=1,rd=3,data=0xA5} with rf_grant=1: rf_we=1, waddr=3, wdata=0xA5 the next cycle; retired_cnt=1 after pop.
- Push rd=0 data=0xFF and a wen=0 entry: rf_we never asserts; each retires in one cycle; retired_cnt=2.
- Hold rf_grant=0, push 3 back-to-back: in_ready drops after 2 accepts; rf_we/addr stable. Release grant: writes occur in order.
- Buffer rd=5=0x11, then rd=5=0x22, grant=0, fwd_rs=5: hit=1, data=0x22. fwd_rt=0: hit=0.
- Stream 10 entries with grant=1 and in_valid continuous: one write per cycle, retired_cnt=10, in_ready stays 1.
- Assert reset with 2 entries buffered: next cycle rf_we=0, hits=0, retired_cnt=0, in_ready=1.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU pipeline definitions: register-file geometry and the write-back entry record.
package cpu_pkg;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;
    localparam int REG_COUNT  = 1 << REG_ADDR_W;

    typedef struct packed {
        logic                  wen;
        logic [REG_ADDR_W-1:0] rd;
        logic [DATA_W-1:0]     data;
    } wb_entry_t;

endpackage

// File: rtl/wb_stage_if.sv
// MEM->WB result handshake and WB->register-file write port.
interface wb_stage_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              in_valid;
    logic              in_ready;
    logic              in_wen;
    logic [ADDR_W-1:0] in_rd;
    logic [DATA_W-1:0] in_data;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic              rf_grant;

    modport master (
        output in_valid, in_wen, in_rd, in_data, rf_grant,
        input  in_ready, rf_we, rf_waddr, rf_wdata
    );

    modport slave (
        input  in_valid, in_wen, in_rd, in_data, rf_grant,
        output in_ready, rf_we, rf_waddr, rf_wdata
    );
endinterface

// File: rtl/wb_fifo.sv
// In-order write-back buffer; exposes every slot and its valid bit for the forwarding search.
module wb_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  wb_entry_t                  push_data,
    input  logic                       pop,
    output wb_entry_t                  head,
    output logic [$clog2(DEPTH):0]     count,
    output logic [$clog2(DEPTH)-1:0]   rd_ptr,
    output wb_entry_t                  entries [DEPTH],
    output logic [DEPTH-1:0]           valid
);
    localparam int PW = $clog2(DEPTH);

    wb_entry_t        mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    offset;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // A slot is live when its distance from the head is below the occupancy.
    always_comb begin
        valid  = '0;
        offset = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            offset   = PW'(i) - rd_ptr;
            valid[i] = {1'b0, offset} < count;
        end
    end

    assign head    = mem[rd_ptr];
    assign entries = mem;

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: buffers MEM results, issues granted register-file writes,
// forwards pending values to ID and counts retired instructions.
module wb_stage
    import cpu_pkg::wb_entry_t;
#(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int ADDR_W = cpu_pkg::REG_ADDR_W,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              reset,
    wb_stage_if.slave         bus,
    input  logic [ADDR_W-1:0] fwd_rs,
    input  logic [ADDR_W-1:0] fwd_rt,
    output logic              fwd_rs_hit,
    output logic              fwd_rt_hit,
    output logic [DATA_W-1:0] fwd_rs_data,
    output logic [DATA_W-1:0] fwd_rt_data,
    output logic [31:0]       retired_cnt
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wb_entry_t          push_entry;
    wb_entry_t          head;
    wb_entry_t          entries [DEPTH];
    logic [DEPTH-1:0]   valid;
    logic [CW-1:0]      count;
    logic [PW-1:0]      rd_ptr;
    logic [PW-1:0]      idx;
    logic               push;
    logic               pop;
    logic               head_writing;

    assign bus.in_ready = count < CW'(DEPTH);
    assign push         = bus.in_valid && bus.in_ready;
    assign push_entry   = '{wen: bus.in_wen, rd: bus.in_rd, data: bus.in_data};

    // Gating with reset keeps the register file untouched in the reset cycle.
    assign head_writing = (count != '0) && head.wen && (head.rd != '0) && reset;
    assign pop          = (count != '0) && reset && (!head_writing || bus.rf_grant);

    assign bus.rf_we    = head_writing;
    assign bus.rf_waddr = head_writing ? head.rd   : '0;
    assign bus.rf_wdata = head_writing ? head.data : '0;

    wb_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .push_data(push_entry),
        .pop      (pop),
        .head     (head),
        .count    (count),
        .rd_ptr   (rd_ptr),
        .entries  (entries),
        .valid    (valid)
    );

    // Walk oldest to youngest so the last match is the youngest pending write.
    always_comb begin
        fwd_rs_hit  = 1'b0;
        fwd_rt_hit  = 1'b0;
        fwd_rs_data = '0;
        fwd_rt_data = '0;
        idx         = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            idx = rd_ptr + PW'(k);
            if (valid[idx] && entries[idx].wen && (entries[idx].rd != '0)) begin
                if (entries[idx].rd == fwd_rs) begin
                    fwd_rs_hit  = 1'b1;
                    fwd_rs_data = entries[idx].data;
                end
                if (entries[idx].rd == fwd_rt) begin
                    fwd_rt_hit  = 1'b1;
                    fwd_rt_data = entries[idx].data;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            retired_cnt <= '0;
        end else if (pop) begin
            retired_cnt <= retired_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: queue-based reference model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_wb_stage;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 2;

    logic              clk;
    logic              reset;
    logic [ADDR_W-1:0] fwd_rs;
    logic [ADDR_W-1:0] fwd_rt;
    logic              fwd_rs_hit;
    logic              fwd_rt_hit;
    logic [DATA_W-1:0] fwd_rs_data;
    logic [DATA_W-1:0] fwd_rt_data;
    logic [31:0]       retired_cnt;

    wb_stage_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    wb_stage #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .fwd_rs     (fwd_rs),
        .fwd_rt     (fwd_rt),
        .fwd_rs_hit (fwd_rs_hit),
        .fwd_rt_hit (fwd_rt_hit),
        .fwd_rs_data(fwd_rs_data),
        .fwd_rt_data(fwd_rt_data),
        .retired_cnt(retired_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    bit model_on = 1'b0;

    typedef struct {
        bit          wen;
        int unsigned rd;
        int unsigned data;
    } ent_t;

    ent_t        q[$];
    int unsigned m_ret = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #3;
    endtask

    task automatic push(input bit wen, input int unsigned rd, input int unsigned data);
        bus.in_valid = 1'b1;
        bus.in_wen   = wen;
        bus.in_rd    = ADDR_W'(rd);
        bus.in_data  = data;
    endtask

    // Reference model: outputs derived from the pending-entry queue, checked mid-cycle.
    initial begin
        bit          exp_ready, exp_we, rs_hit, rt_hit, do_pop, do_push;
        int unsigned exp_addr, exp_data, rs_data, rt_data;
        wait (model_on);
        forever begin
            @(negedge clk);
            exp_ready = q.size() < DEPTH;
            exp_we    = reset && q.size() > 0 && q[0].wen && q[0].rd != 0;
            exp_addr  = exp_we ? q[0].rd   : 0;
            exp_data  = exp_we ? q[0].data : 0;
            rs_hit = 0; rt_hit = 0; rs_data = 0; rt_data = 0;
            foreach (q[i]) begin
                if (q[i].wen && q[i].rd != 0) begin
                    if (q[i].rd == fwd_rs) begin rs_hit = 1; rs_data = q[i].data; end
                    if (q[i].rd == fwd_rt) begin rt_hit = 1; rt_data = q[i].data; end
                end
            end
            chk("m_in_ready",   32'(bus.in_ready),  32'(exp_ready));
            chk("m_rf_we",      32'(bus.rf_we),     32'(exp_we));
            chk("m_rf_waddr",   32'(bus.rf_waddr),  exp_addr);
            chk("m_rf_wdata",   bus.rf_wdata,       exp_data);
            chk("m_rs_hit",     32'(fwd_rs_hit),    32'(rs_hit));
            chk("m_rs_data",    fwd_rs_data,        rs_data);
            chk("m_rt_hit",     32'(fwd_rt_hit),    32'(rt_hit));
            chk("m_rt_data",    fwd_rt_data,        rt_data);
            chk("m_retired",    retired_cnt,        m_ret);

            @(posedge clk);
            if (!reset) begin
                q.delete();
                m_ret = 0;
            end else begin
                do_pop  = q.size() > 0 && (!(q[0].wen && q[0].rd != 0) || bus.rf_grant);
                do_push = bus.in_valid && q.size() < DEPTH;
                if (do_pop) begin
                    void'(q.pop_front());
                    m_ret++;
                end
                if (do_push) q.push_back('{wen: bus.in_wen, rd: 32'(bus.in_rd), data: bus.in_data});
            end
        end
    end

    initial begin
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_wen   = 1'b0;
        bus.in_rd    = '0;
        bus.in_data  = '0;
        bus.rf_grant = 1'b0;
        fwd_rs       = '0;
        fwd_rt       = '0;
        step();
        step();
        reset    = 1'b1;
        model_on = 1'b1;

        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_rf_we",    32'(bus.rf_we),    32'd0);
        chk("rst_waddr",    32'(bus.rf_waddr), 32'd0);
        chk("rst_wdata",    bus.rf_wdata,      32'd0);
        chk("rst_rs_hit",   32'(fwd_rs_hit),   32'd0);
        chk("rst_rt_hit",   32'(fwd_rt_hit),   32'd0);
        chk("rst_retired",  retired_cnt,       32'd0);

        // Single write, granted immediately
        bus.rf_grant = 1'b1;
        push(1, 3, 32'hA5);
        step();
        bus.in_valid = 1'b0;
        chk("t1_rf_we",  32'(bus.rf_we),    32'd1);
        chk("t1_waddr",  32'(bus.rf_waddr), 32'd3);
        chk("t1_wdata",  bus.rf_wdata,      32'hA5);
        step();
        chk("t1_retired", retired_cnt, 32'd1);
        chk("t1_idle_we", 32'(bus.rf_we), 32'd0);

        // r0 target and wen=0 retire without writing
        push(1, 0, 32'hFF);
        step();
        push(0, 7, 32'h1234);
        chk("t2_r0_we", 32'(bus.rf_we), 32'd0);
        step();
        bus.in_valid = 1'b0;
        chk("t2_nowen_we", 32'(bus.rf_we), 32'd0);
        step();
        chk("t2_retired", retired_cnt, 32'd3);

        // Back-pressure with grant withheld
        bus.rf_grant = 1'b0;
        push(1, 1, 32'h101);
        step();
        push(1, 2, 32'h102);
        step();
        push(1, 3, 32'h103);
        chk("t3_full_ready", 32'(bus.in_ready), 32'd0);
        chk("t3_held_we",    32'(bus.rf_we),    32'd1);
        chk("t3_held_addr",  32'(bus.rf_waddr), 32'd1);
        step();
        chk("t3_still_full", 32'(bus.in_ready), 32'd0);
        chk("t3_stable_addr", 32'(bus.rf_waddr), 32'd1);
        chk("t3_stable_data", bus.rf_wdata,      32'h101);
        bus.rf_grant = 1'b1;
        step();
        chk("t3_ready_again", 32'(bus.in_ready), 32'd1);
        chk("t3_second_addr", 32'(bus.rf_waddr), 32'd2);
        step();
        bus.in_valid = 1'b0;
        chk("t3_third_addr", 32'(bus.rf_waddr), 32'd3);
        chk("t3_third_data", bus.rf_wdata,      32'h103);
        step();
        chk("t3_drained_we", 32'(bus.rf_we), 32'd0);
        chk("t3_retired",    retired_cnt,    32'd6);

        // Forwarding picks the youngest pending write
        bus.rf_grant = 1'b0;
        push(1, 5, 32'h11);
        step();
        push(1, 5, 32'h22);
        step();
        bus.in_valid = 1'b0;
        fwd_rs = 5'd5;
        fwd_rt = 5'd0;
        #1;
        chk("t4_rs_hit",  32'(fwd_rs_hit), 32'd1);
        chk("t4_rs_data", fwd_rs_data,     32'h22);
        chk("t4_rt_hit",  32'(fwd_rt_hit), 32'd0);
        chk("t4_rt_data", fwd_rt_data,     32'd0);
        bus.rf_grant = 1'b1;
        step();
        chk("t4_rs_hit_one",  32'(fwd_rs_hit), 32'd1);
        chk("t4_rs_data_one", fwd_rs_data,     32'h22);
        step();
        chk("t4_rs_hit_gone",  32'(fwd_rs_hit), 32'd0);
        chk("t4_rs_data_gone", fwd_rs_data,     32'd0);
        chk("t4_retired",      retired_cnt,     32'd8);

        // Reset with entries buffered
        bus.rf_grant = 1'b0;
        push(1, 9, 32'h99);
        step();
        push(1, 10, 32'h1010);
        step();
        bus.in_valid = 1'b0;
        fwd_rs = 5'd9;
        #1;
        chk("t6_pre_hit", 32'(fwd_rs_hit), 32'd1);
        reset = 1'b0;
        #1;
        chk("t6_rst_cycle_we", 32'(bus.rf_we), 32'd0);
        step();
        reset = 1'b1;
        chk("t6_we",      32'(bus.rf_we),    32'd0);
        chk("t6_hit",     32'(fwd_rs_hit),   32'd0);
        chk("t6_retired", retired_cnt,       32'd0);
        chk("t6_ready",   32'(bus.in_ready), 32'd1);

        // Streaming at one per cycle
        bus.rf_grant = 1'b1;
        for (int i = 0; i < 10; i++) begin
            push(1, 32'(i + 1), $urandom);
            step();
            chk("t5_ready", 32'(bus.in_ready), 32'd1);
        end
        bus.in_valid = 1'b0;
        step();
        chk("t5_retired", retired_cnt,   32'd10);
        chk("t5_idle_we", 32'(bus.rf_we), 32'd0);

        // Randomized traffic against the model
        for (int c = 0; c < 1500; c++) begin
            reset        = ($urandom_range(0, 199) != 0);
            bus.in_valid = $urandom_range(0, 1) == 1;
            bus.in_wen   = $urandom_range(0, 3) != 0;
            bus.in_rd    = ADDR_W'($urandom_range(0, 7));
            bus.in_data  = $urandom;
            bus.rf_grant = $urandom_range(0, 9) < 7;
            fwd_rs       = ADDR_W'($urandom_range(0, 7));
            fwd_rt       = ADDR_W'($urandom_range(0, 7));
            step();
        end
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.rf_grant = 1'b1;
        repeat (4) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
